// File: rtl/bemicro_cv_ddr3_control_dmaster_b2p_pkg.sv
// Shared framing definitions for the DDR3 control debug master byte/packet
// converters. The packets-to-bytes encoder imports the same constants so both
// directions agree on the in-band character set.
package bemicro_cv_dmaster_pkg;

   // In-band framing characters
   localparam logic [7:0] SOP_CHAR  = 8'h7A;
   localparam logic [7:0] EOP_CHAR  = 8'h7B;
   localparam logic [7:0] CHAN_CHAR = 8'h7C;
   localparam logic [7:0] ESC_CHAR  = 8'h7D;

   // An escaped byte is transmitted as ESC_CHAR followed by byte ^ ESC_XOR
   localparam logic [7:0] ESC_XOR   = 8'h20;

   // Decoder state carried between accepted bytes
   typedef struct packed {
      logic sop_pend;   // next output byte starts a packet
      logic eop_pend;   // next output byte ends a packet
      logic chan_pend;  // next value byte is a channel number
      logic esc_pend;   // next byte is escaped and must be un-XORed
   } b2p_flags_t;

   localparam b2p_flags_t FLAGS_CLEAR = '{default: 1'b0};

   // Meaning of one accepted input byte
   typedef enum logic [2:0] {
      BYTE_SOP,
      BYTE_EOP,
      BYTE_CHAN,
      BYTE_ESC,
      BYTE_VALUE
   } byte_kind_e;

   // True for any byte that needs escaping on the wire
   function automatic logic is_framing_char(input logic [7:0] b);
      return (b == SOP_CHAR) || (b == EOP_CHAR) ||
             (b == CHAN_CHAR) || (b == ESC_CHAR);
   endfunction

   // Classify a byte; anything following an escape is always a value
   function automatic byte_kind_e classify_byte(input logic [7:0] b,
                                                input logic       escaped);
      byte_kind_e kind;
      kind = BYTE_VALUE;
      if (!escaped && is_framing_char(b)) begin
         case (b)
            SOP_CHAR:  kind = BYTE_SOP;
            EOP_CHAR:  kind = BYTE_EOP;
            CHAN_CHAR: kind = BYTE_CHAN;
            default:   kind = BYTE_ESC;
         endcase
      end
      return kind;
   endfunction

   // Recover the literal value of a value byte
   function automatic logic [7:0] decode_value(input logic [7:0] b,
                                               input logic       escaped);
      return escaped ? (b ^ ESC_XOR) : b;
   endfunction

endpackage

// File: rtl/bemicro_cv_ddr3_control_dmaster_b2p_oreg.sv
// Ready/valid output register for the bytes-to-packets decoder. Holds the
// decoded byte with its sidebands and channel, keeps them stable while the
// sink stalls, and reports when it can take a new byte (empty or draining).
module bemicro_cv_dmaster_b2p_oreg #(
   parameter int CHANNEL_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [7:0]           load_data,
   input  logic                 load_sop,
   input  logic                 load_eop,
   input  logic [CHANNEL_W-1:0] load_channel,
   output logic                 can_load,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic                 out_startofpacket,
   output logic                 out_endofpacket,
   output logic [CHANNEL_W-1:0] out_channel,
   input  logic                 out_ready
);

   // Space is available when empty, or when the held byte leaves this cycle
   assign can_load = !out_valid || out_ready;

   // Output register: load wins over drain so back-to-back bytes flow at 1/clk
   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_channel       <= '0;
      end else if (load) begin
         out_valid         <= 1'b1;
         out_data          <= load_data;
         out_startofpacket <= load_sop;
         out_endofpacket   <= load_eop;
         out_channel       <= load_channel;
      end else if (out_ready) begin
         out_valid         <= 1'b0;
      end
   end

endmodule

// File: rtl/bemicro_cv_ddr3_control_dmaster_b2p.sv
// Bytes-to-packets decoder for the DDR3 control debug master. Consumes the
// escaped 8-bit byte stream from the timing adapter, strips SOP/EOP/channel/
// escape characters and presents Avalon-ST packets with sidebands.
// Optional build macro BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN adds a sticky
// proto_err output flagging data outside a packet or a SOP inside one.
module bemicro_cv_ddr3_control_dmaster_b2p
   import bemicro_cv_dmaster_pkg::*;
#(
   parameter int CHANNEL_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [7:0]           in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic                 out_startofpacket,
   output logic                 out_endofpacket,
   output logic [CHANNEL_W-1:0] out_channel,
`ifdef BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN
   output logic                 proto_err,
`endif
   input  logic                 out_ready
);

   b2p_flags_t           flags, flags_nxt;
   logic [CHANNEL_W-1:0] channel_q, channel_nxt;
   byte_kind_e           kind;
   logic [7:0]           value;
   logic                 accept;
   logic                 load;

   assign accept = in_valid && in_ready;

   // Decode the byte currently offered upstream
   always_comb begin
      kind  = classify_byte(in_data, flags.esc_pend);
      value = decode_value(in_data, flags.esc_pend);
   end

   // Next flag/channel state and the output-register load strobe
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      flags_nxt   = flags;
      channel_nxt = channel_q;
      load        = 1'b0;
      if (accept) begin
         case (kind)
            BYTE_SOP:  flags_nxt.sop_pend  = 1'b1;
            BYTE_EOP:  flags_nxt.eop_pend  = 1'b1;
            BYTE_CHAN: flags_nxt.chan_pend = 1'b1;
            BYTE_ESC:  flags_nxt.esc_pend  = 1'b1;
            default: begin
               flags_nxt.esc_pend = 1'b0;
               if (flags.chan_pend) begin
                  channel_nxt         = value[CHANNEL_W-1:0];
                  flags_nxt.chan_pend = 1'b0;
               end else begin
                  load               = 1'b1;
                  flags_nxt.sop_pend = 1'b0;
                  flags_nxt.eop_pend = 1'b0;
               end
            end
         endcase
      end
   end

   // Pending flags and current channel
   always_ff @(posedge clk) begin
      if (reset) begin
         flags     <= FLAGS_CLEAR;
         channel_q <= '0;
      end else begin
         flags     <= flags_nxt;
         channel_q <= channel_nxt;
      end
   end

   bemicro_cv_dmaster_b2p_oreg #(
      .CHANNEL_W (CHANNEL_W)
   ) u_oreg (
      .clk               (clk),
      .reset             (reset),
      .load              (load),
      .load_data         (value),
      .load_sop          (flags.sop_pend),
      .load_eop          (flags.eop_pend),
      .load_channel      (channel_q),
      .can_load          (in_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_channel       (out_channel),
      .out_ready         (out_ready)
   );

`ifdef BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN
   logic packet_open, packet_open_nxt;
   logic err_event;

   // Packet-open tracking and protocol violation detection
   always_comb begin
      packet_open_nxt = packet_open;
      err_event       = 1'b0;
      if (accept && (kind == BYTE_SOP) && packet_open) begin
         err_event = 1'b1;
      end
      if (load) begin
         // A pending SOP opens the packet this byte belongs to
         if (!packet_open && !flags.sop_pend) begin
            err_event = 1'b1;
         end
         packet_open_nxt = (packet_open || flags.sop_pend) && !flags.eop_pend;
      end
   end

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         packet_open <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         packet_open <= packet_open_nxt;
         proto_err   <= proto_err || err_event;
      end
   end
`endif

endmodule

// File: tb/tb_bemicro_cv_ddr3_control_dmaster_b2p.sv
// Scoreboard bench for the bytes-to-packets decoder: directed byte streams
// push hand-computed expected packets; a negedge monitor pops and compares on
// every output handshake, including acceptance-to-output latency.
module tb_bemicro_cv_ddr3_control_dmaster_b2p;

   localparam int CW = 4;

   typedef struct {
      logic [7:0]    data;
      logic          sop;
      logic          eop;
      logic [CW-1:0] ch;
      int            acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_sop;
   logic          out_eop;
   logic [CW-1:0] out_channel;
   logic          out_ready;
`ifdef BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN
   logic          proto_err;
`endif

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   seen  = 0;
   int   seen_cyc = 0;

   bemicro_cv_ddr3_control_dmaster_b2p #(
      .CHANNEL_W (CW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_ready          (in_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_channel       (out_channel),
`ifdef BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN
      .proto_err         (proto_err),
`endif
      .out_ready         (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: stamp when each output byte first appears, compare on handshake
   always @(negedge clk) begin
      if (reset) begin
         seen = 0;
      end else begin
         if (out_valid && !seen) begin
            seen     = 1;
            seen_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got data %0h, nothing expected", out_data);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("out_data", out_data, e.data);
               check("out_sop", out_sop, e.sop);
               check("out_eop", out_eop, e.eop);
               check("out_channel", out_channel, e.ch);
               check("latency", seen_cyc - e.acc, 0);
            end
            seen = 0;
         end
      end
   end

   // Offer one byte; called and returns at 1 time unit after a rising edge
   task automatic send_byte(input logic [7:0] b, input bit push, input logic [7:0] d,
                            input logic sop, input logic eop, input logic [CW-1:0] ch);
      int   n;
      exp_t e;
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1 for byte %0h", b);
      end else if (push) begin
         e.data = d;
         e.sop  = sop;
         e.eop  = eop;
         e.ch   = ch;
         e.acc  = cyc + 1;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic mark(input logic [7:0] b);
      send_byte(b, 1'b0, 8'h00, 1'b0, 1'b0, '0);
   endtask

   task automatic val(input logic [7:0] b, input logic [7:0] d, input logic sop,
                      input logic eop, input logic [CW-1:0] ch);
      send_byte(b, 1'b1, d, sop, eop, ch);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [CW-1:0] ch7c;
      ch7c      = CW'(8'h7C);
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sop", out_sop, 0);
      check("rst_out_eop", out_eop, 0);
      check("rst_out_channel", out_channel, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN
      check("rst_proto_err", proto_err, 0);
`endif
      @(posedge clk);
      #1;

      // 1: basic packet at full throughput
      mark(8'h7A);
      val(8'h11, 8'h11, 1, 0, 0);
      val(8'h22, 8'h22, 0, 0, 0);
      mark(8'h7B);
      val(8'h33, 8'h33, 0, 1, 0);
      drain();

      // 2: channel then single-byte packet
      mark(8'h7C);
      val(8'h05, 8'h00, 0, 0, 0);
      void'(q.pop_back());  // channel value produces no output
      mark(8'h7A);
      mark(8'h7B);
      val(8'h44, 8'h44, 1, 1, 4'h5);
      drain();

      // 3: escaped framing characters as data
      mark(8'h7A);
      mark(8'h7D);
      val(8'h5A, 8'h7A, 1, 0, 4'h5);
      mark(8'h7D);
      val(8'h5D, 8'h7D, 0, 0, 4'h5);
      mark(8'h7B);
      mark(8'h7D);
      val(8'h5B, 8'h7B, 0, 1, 4'h5);
      drain();

      // 4: downstream stall holds output and blocks input
      out_ready = 1'b0;
      mark(8'h7A);
      val(8'h01, 8'h01, 1, 0, 4'h5);
      in_valid = 1'b1;
      in_data  = 8'h02;
      repeat (5) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_data", out_data, 8'h01);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      val(8'h02, 8'h02, 0, 0, 4'h5);
      val(8'h03, 8'h03, 0, 0, 4'h5);
      drain();

      // 5: reset mid-packet drops held byte and flags
      out_ready = 1'b0;
      mark(8'h7A);
      mark(8'hAA);  // held in output register, then discarded by reset
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_sop", out_sop, 0);
      check("mid_rst_out_channel", out_channel, 0);
`ifdef BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN
      check("mid_rst_proto_err", proto_err, 0);
`endif
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      val(8'h55, 8'h55, 0, 0, 0);
      drain();
`ifdef BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN
      check("proto_err_after_55", proto_err, 1);
`endif

      // 6: escaped channel value, truncated to CW bits
      mark(8'h7C);
      mark(8'h7D);
      val(8'h5C, 8'h00, 0, 0, 0);
      void'(q.pop_back());
      mark(8'h7A);
      mark(8'h7B);
      val(8'h66, 8'h66, 1, 1, ch7c);
      drain();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bemicro_cv_ddr3_control_dmaster_b2p.md
Name: bemicro_cv_ddr3_control_dmaster_b2p

Overview:
Bytes-to-packets decoder for the DDR3 control debug master.
- Sits directly downstream of the dmaster timing adapter and consumes its 8-bit Avalon-ST byte stream.
- Strips the in-band framing characters (SOP, EOP, channel, escape) and emits Avalon-ST packets with startofpacket/endofpacket/channel sidebands toward the transaction decoder.
- Provides real backpressure upstream through in_ready.

Parameters:
CHANNEL_W, 8, width of out_channel (1..8); the decoded channel byte is truncated to its low CHANNEL_W bits.

Ports:
clk  input  1  single clock, all logic rising-edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  upstream byte valid.
in_data  input  8  upstream byte.
in_ready  output  1  decoder can accept a byte this cycle.
out_valid  output  1  decoded data byte valid.
out_data  output  8  decoded data byte.
out_startofpacket  output  1  first byte of packet.
out_endofpacket  output  1  last byte of packet.
out_channel  output  CHANNEL_W  channel of current byte.
out_ready  input  1  downstream accepts.

Behaviour:
Reset and handshake
- Reset values: out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0; all pending flags (sop_pend, eop_pend, chan_pend, esc_pend) cleared.
- in_ready = !out_valid || out_ready, registered-free combinational.
- A byte is accepted when in_valid && in_ready.

Framing characters (accepted, with esc_pend=0)
- 0x7A: set sop_pend; no output.
- 0x7B: set eop_pend; no output.
- 0x7C: set chan_pend; no output.
- 0x7D: set esc_pend; no output.

Value bytes
- A value byte is any other byte, or any byte accepted while esc_pend=1.
- Decoded value = esc_pend ? byte^8'h20 : byte. esc_pend clears on use.
- If chan_pend=1: the value loads the channel register (low CHANNEL_W bits); chan_pend clears; no output.
- Otherwise: the output register loads the value next cycle (latency 1 cycle from acceptance to out_valid).
  - out_startofpacket=sop_pend, out_endofpacket=eop_pend, out_channel=channel register.
  - sop_pend and eop_pend clear.
- out_* hold stable while out_valid && !out_ready.
- out_valid drops after a handshake unless a new value byte is accepted in the same cycle, giving full throughput of 1 byte/clk.

Boundary cases
- SOP and EOP markers both before one value: single-byte packet with both sidebands set.
- Repeated marker: idempotent (flag stays set).
- Escape immediately followed by 0x7A..0x7D: literal data 0x5A..0x5D.
- Channel marker followed by escape: the escaped value becomes the channel.
- Channel persists across packets until changed.
- Reset mid-packet: all flags and the output are dropped; nothing is replayed.

Optional Feature:
Macro BEMICRO_CV_DMASTER_B2P_PROTO_ERR_EN.
- Defined: adds output proto_err (1 bit, reset 0, sticky until reset). It is set one cycle after either of these is accepted:
  - a value byte destined for output while no packet is open (no SOP since the last EOP);
  - a SOP marker while a packet is open.
  - Data still passes through unchanged.
- Undefined: no port and no packet-open tracking logic.

Decomposition:
- Package bemicro_cv_dmaster_pkg holds: SOP_CHAR=8'h7A, EOP_CHAR=8'h7B, CHAN_CHAR=8'h7C, ESC_CHAR=8'h7D, ESC_XOR=8'h20, plus a typedef for the decoder flag struct. The packets-to-bytes encoder reuses the same package.
- One natural sub-module: bemicro_cv_dmaster_b2p_oreg, the ready/valid output register holding data, sidebands and channel.

Test Plan:
1. Stream 7A,11,22,7B,33 with out_ready=1 -> outputs 11(sop=1), 22, 33(eop=1), one per cycle, each 1 cycle after acceptance.
2. Stream 7C,05,7A,7B,44 -> single output 44 with sop=1, eop=1, channel=5.
3. Stream 7A,7D,5A,7D,5D,7B,7D,5B -> data 7A(sop), 7D, 7B(eop).
4. Send 7A,01,02,03 with out_ready held 0 for 5 cycles -> in_ready=0 after first data byte accepted; out_data=01 held stable; after release, 01,02,03 delivered with no loss or duplicates.
5. Send 7A,AA, then assert reset for 1 cycle mid-stream, then 55 -> all outputs 0 after reset; 55 emitted with sop=0, channel=0 (proto_err=1 when macro defined).
6. Stream 7C,7D,5C,7A,7B,66 -> channel=0x7C truncated to CHANNEL_W; with CHANNEL_W=4, out_channel=4'hC.
